// File: rtl/vga_timing_monitor.sv
// Receive-side VGA sync checker: measures line/hsync/frame timing, rebuilds pixel position, declares lock.
// All outputs registered, 1 CLK_40 after the sample; passive observer with no backpressure.
module vga_timing_monitor #(
  parameter int   H_AREA      = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_AREA      = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_POL    = 1'b1,
  parameter int   LOCK_FRAMES = 2
) (
  input  logic        CLK_40,
  input  logic        reset,
  input  logic        pixel_en,
  input  logic        hsync_n,
  input  logic        vsync_n,
  output logic [10:0] rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_active,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [10:0] hsync_len,
  output logic [9:0]  frame_lines,
  output logic        err_line,
  output logic        err_hsync,
  output logic        err_frame,
  output logic [7:0]  err_count
);

  localparam logic [10:0] H_TOTAL  = 11'(H_AREA + H_FP + H_SYNC + H_BP);
  localparam logic [9:0]  V_TOTAL  = 10'(V_AREA + V_FP + V_SYNC + V_BP);
  localparam logic [10:0] H_LAST   = H_TOTAL - 11'd1;
  localparam logic [9:0]  V_LAST   = V_TOTAL - 10'd1;
  localparam logic [10:0] X_AT_HS  = 11'(H_AREA + H_FP);
  localparam logic [9:0]  Y_AT_VS  = 10'(V_AREA + V_FP);
  localparam logic [10:0] HS_MIN   = 11'(H_SYNC - 1);
  localparam logic [10:0] HS_MAX   = 11'(H_SYNC + 1);
  localparam logic [10:0] H_AREA_W = 11'(H_AREA);
  localparam logic [9:0]  V_AREA_W = 10'(V_AREA);
  localparam logic [2:0]  LOCK_N   = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t      state, state_nxt;
  logic        hs_prev, vs_prev, hs_prev_nxt, vs_prev_nxt;
  logic [10:0] h_cnt, hs_w, h_cnt_nxt, hs_w_nxt;
  logic [9:0]  v_cnt, v_cnt_nxt;
  logic [2:0]  good_frames, good_nxt;
  logic        skip_line, skip_frame, frame_bad;
  logic        skip_line_nxt, skip_frame_nxt, frame_bad_nxt;

  logic [10:0] rx_x_nxt, line_len_nxt, hsync_len_nxt;
  logic [9:0]  rx_y_nxt, frame_lines_nxt;
  logic        rx_active_nxt, locked_nxt;
  logic        err_line_nxt, err_hsync_nxt, err_frame_nxt, err_now;
  logic [7:0]  err_count_nxt;

  logic        hs_on, vs_on, hs_lead, hs_trail, vs_lead, x_wrap, checking, any_err_q;
  logic [10:0] h_inc, hs_w_inc;
  logic [9:0]  v_inc;

  assign hs_on     = (hsync_n == SYNC_POL);
  assign vs_on     = (vsync_n == SYNC_POL);
  assign hs_lead   = pixel_en && hs_on && (hs_prev != SYNC_POL);
  assign hs_trail  = pixel_en && !hs_on && (hs_prev == SYNC_POL);
  assign vs_lead   = pixel_en && vs_on && (vs_prev != SYNC_POL);
  assign h_inc     = (h_cnt == 11'h7FF) ? h_cnt : h_cnt + 11'd1;
  assign hs_w_inc  = (hs_w == 11'h7FF) ? hs_w : hs_w + 11'd1;
  // A coincident hsync edge belongs to the frame that the vsync edge closes.
  assign v_inc     = (!hs_lead || v_cnt == 10'h3FF) ? v_cnt : v_cnt + 10'd1;
  assign x_wrap    = !hs_lead && (rx_x == H_LAST);
  assign checking  = (state != SEARCH);
  assign any_err_q = err_line | err_hsync | err_frame;

  always_comb begin
    state_nxt       = state;
    hs_prev_nxt     = hs_prev;
    vs_prev_nxt     = vs_prev;
    h_cnt_nxt       = h_cnt;
    hs_w_nxt        = hs_w;
    v_cnt_nxt       = v_cnt;
    good_nxt        = good_frames;
    skip_line_nxt   = skip_line;
    skip_frame_nxt  = skip_frame;
    frame_bad_nxt   = frame_bad;
    rx_x_nxt        = rx_x;
    rx_y_nxt        = rx_y;
    line_len_nxt    = line_len;
    hsync_len_nxt   = hsync_len;
    frame_lines_nxt = frame_lines;
    err_line_nxt    = 1'b0;
    err_hsync_nxt   = 1'b0;
    err_frame_nxt   = 1'b0;
    err_now         = 1'b0;
    err_count_nxt   = (any_err_q && err_count != 8'hFF) ? err_count + 8'd1 : err_count;

    if (pixel_en) begin
      hs_prev_nxt = hsync_n;
      vs_prev_nxt = vsync_n;

      if (hs_lead) begin
        h_cnt_nxt     = 11'd0;
        line_len_nxt  = h_inc;
        skip_line_nxt = 1'b0;
        err_line_nxt  = checking && !skip_line && (h_inc != H_TOTAL);
      end else begin
        h_cnt_nxt = h_inc;
      end

      if (hs_trail) begin
        hsync_len_nxt = hs_w;
        hs_w_nxt      = 11'd0;
        err_hsync_nxt = checking && ((hs_w < HS_MIN) || (hs_w > HS_MAX));
      end else if (hs_on) begin
        hs_w_nxt = hs_w_inc;
      end

      if (vs_lead) begin
        frame_lines_nxt = v_inc;
        v_cnt_nxt       = 10'd0;
        err_frame_nxt   = checking && !skip_frame && (v_inc != V_TOTAL);
      end else begin
        v_cnt_nxt = v_inc;
      end

      if (hs_lead)     rx_x_nxt = X_AT_HS;
      else if (x_wrap) rx_x_nxt = 11'd0;
      else             rx_x_nxt = rx_x + 11'd1;

      if (vs_lead)     rx_y_nxt = Y_AT_VS;
      else if (x_wrap) rx_y_nxt = (rx_y == V_LAST) ? 10'd0 : rx_y + 10'd1;

      err_now = err_line_nxt | err_hsync_nxt | err_frame_nxt;

      unique case (state)
        SEARCH: begin
          if (vs_lead) begin
            state_nxt      = TRACK;
            good_nxt       = 3'd0;
            skip_line_nxt  = 1'b1;
            skip_frame_nxt = 1'b1;
            frame_bad_nxt  = 1'b0;
          end
        end
        TRACK: begin
          if (err_now) frame_bad_nxt = 1'b1;
          // The first vsync in TRACK only opens the scoring window.
          if (vs_lead) begin
            frame_bad_nxt = 1'b0;
            if (skip_frame) begin
              skip_frame_nxt = 1'b0;
            end else if (frame_bad || err_now) begin
              good_nxt = 3'd0;
            end else begin
              good_nxt = good_frames + 3'd1;
              if (good_frames + 3'd1 == LOCK_N) state_nxt = LOCKED;
            end
          end
        end
        default: ;
      endcase
    end

    // Lock is dropped from the registered pulse, so it falls one cycle after the error.
    if (state == LOCKED && any_err_q) state_nxt = SEARCH;

    locked_nxt    = (state_nxt == LOCKED);
    rx_active_nxt = locked_nxt && (rx_x_nxt < H_AREA_W) && (rx_y_nxt < V_AREA_W);
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state       <= SEARCH;
      hs_prev     <= ~SYNC_POL;
      vs_prev     <= ~SYNC_POL;
      h_cnt       <= 11'd0;
      hs_w        <= 11'd0;
      v_cnt       <= 10'd0;
      good_frames <= 3'd0;
      skip_line   <= 1'b0;
      skip_frame  <= 1'b0;
      frame_bad   <= 1'b0;
      rx_x        <= 11'd0;
      rx_y        <= 10'd0;
      rx_active   <= 1'b0;
      locked      <= 1'b0;
      line_len    <= 11'd0;
      hsync_len   <= 11'd0;
      frame_lines <= 10'd0;
      err_line    <= 1'b0;
      err_hsync   <= 1'b0;
      err_frame   <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state       <= state_nxt;
      hs_prev     <= hs_prev_nxt;
      vs_prev     <= vs_prev_nxt;
      h_cnt       <= h_cnt_nxt;
      hs_w        <= hs_w_nxt;
      v_cnt       <= v_cnt_nxt;
      good_frames <= good_nxt;
      skip_line   <= skip_line_nxt;
      skip_frame  <= skip_frame_nxt;
      frame_bad   <= frame_bad_nxt;
      rx_x        <= rx_x_nxt;
      rx_y        <= rx_y_nxt;
      rx_active   <= rx_active_nxt;
      locked      <= locked_nxt;
      line_len    <= line_len_nxt;
      hsync_len   <= hsync_len_nxt;
      frame_lines <= frame_lines_nxt;
      err_line    <= err_line_nxt;
      err_hsync   <= err_hsync_nxt;
      err_frame   <= err_frame_nxt;
      err_count   <= err_count_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor on a scaled-down 32x12 raster (16x6 active).
module tb_vga_timing_monitor;

  localparam int   HA = 16, HF = 4, HS = 8, HB = 4;
  localparam int   VA = 6, VF = 2, VS = 2, VB = 2;
  localparam int   HT = HA + HF + HS + HB;   // 32
  localparam int   VT = VA + VF + VS + VB;   // 12
  localparam int   HS0 = HA + HF;            // 20
  localparam int   VS0 = VA + VF;            // 8
  localparam logic SP = 1'b1;

  logic        CLK_40, reset, pixel_en, hsync_n, vsync_n;
  logic [10:0] rx_x, line_len, hsync_len;
  logic [9:0]  rx_y, frame_lines;
  logic        rx_active, locked, err_line, err_hsync, err_frame;
  logic [7:0]  err_count;

  vga_timing_monitor #(
    .H_AREA(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_AREA(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(SP), .LOCK_FRAMES(2)
  ) dut (
    .CLK_40(CLK_40), .reset(reset), .pixel_en(pixel_en),
    .hsync_n(hsync_n), .vsync_n(vsync_n),
    .rx_x(rx_x), .rx_y(rx_y), .rx_active(rx_active), .locked(locked),
    .line_len(line_len), .hsync_len(hsync_len), .frame_lines(frame_lines),
    .err_line(err_line), .err_hsync(err_hsync), .err_frame(err_frame),
    .err_count(err_count)
  );

  initial CLK_40 = 1'b0;
  always #5 CLK_40 = ~CLK_40;

  int n_cmp = 0, n_bad = 0;
  int n_el = 0, n_eh = 0, n_ef = 0;
  int en_div = 4;
  logic       a_err_line, a_err_hsync, a_err_frame, a_locked, b_locked;
  logic [7:0] a_err_count, b_err_count;

  always @(negedge CLK_40) begin
    if (err_line)  n_el <= n_el + 1;
    if (err_hsync) n_eh <= n_eh + 1;
    if (err_frame) n_ef <= n_ef + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample; snapshots just after the sample edge (a_*) and one cycle later (b_*).
  task automatic pix(input bit hs, input bit vs);
    hsync_n  = hs ? SP : ~SP;
    vsync_n  = vs ? SP : ~SP;
    pixel_en = 1'b1;
    @(posedge CLK_40); #1;
    pixel_en    = 1'b0;
    a_err_line  = err_line;
    a_err_hsync = err_hsync;
    a_err_frame = err_frame;
    a_locked    = locked;
    a_err_count = err_count;
    @(posedge CLK_40); #1;
    b_locked    = locked;
    b_err_count = err_count;
    repeat (en_div - 2) begin @(posedge CLK_40); #1; end
  endtask

  task automatic span(input int y, input int x0, input int x1, input int hsw);
    for (int x = x0; x < x1; x++)
      pix((x >= HS0) && (x < HS0 + hsw), (y >= VS0) && (y < VS0 + VS));
  endtask

  task automatic lines(input int y0, input int y1);
    for (int y = y0; y < y1; y++) span(y, 0, HT, HS);
  endtask

  initial begin
    reset = 1'b1; pixel_en = 1'b0; hsync_n = ~SP; vsync_n = ~SP;
    repeat (3) @(posedge CLK_40);
    #1;
    check("reset rx_x", rx_x, 0);
    check("reset rx_y", rx_y, 0);
    check("reset locked", locked, 0);
    check("reset line_len", line_len, 0);
    check("reset frame_lines", frame_lines, 0);
    check("reset err_count", err_count, 0);
    reset = 1'b0;

    // Nominal stream, 1-in-4 enable: lock on the 4th vsync edge.
    lines(0, VT); lines(0, VT); lines(0, VT);
    lines(0, VS0);
    check("nominal locked before v4", locked, 0);
    span(VS0, 0, 1, HS);
    check("nominal locked at v4", a_locked, 1);
    check("nominal line_len", line_len, HT);
    check("nominal hsync_len", hsync_len, HS);
    check("nominal frame_lines", frame_lines, VT);
    check("nominal err_count", err_count, 0);
    span(VS0, 1, HT, HS); lines(VS0 + 1, VT - 1);
    span(VT - 1, 0, HT - 1, HS);
    check("rx_active in blanking", rx_active, 0);
    span(VT - 1, HT - 1, HT, HS);
    span(0, 0, 1, HS);
    check("first active rx_x", rx_x, 0);
    check("first active rx_y", rx_y, 0);
    check("first active rx_active", rx_active, 1);
    span(0, 1, HT, HS); lines(1, 2);
    span(2, 0, 6, HS);
    check("mid rx_x", rx_x, 5);
    check("mid rx_y", rx_y, 2);
    check("mid rx_active", rx_active, 1);
    span(2, 6, HT, HS);

    // One short line while locked.
    en_div = 2;
    span(3, 0, HT - 1, HS);
    span(4, 0, HS0, HS);
    span(4, HS0, HS0 + 1, HS);
    check("short err_line", a_err_line, 1);
    check("short locked same cycle", a_locked, 1);
    check("short err_count same cycle", a_err_count, 0);
    check("short line_len", line_len, HT - 1);
    check("short rx_x reload", rx_x, HS0);
    check("short locked next cycle", b_locked, 0);
    check("short err_count next cycle", b_err_count, 1);
    span(4, HS0 + 1, HT, HS); lines(5, VT);
    lines(0, VT); lines(0, VT);
    lines(0, VS0);
    check("relock before", locked, 0);
    span(VS0, 0, 1, HS);
    check("relock after", a_locked, 1);
    check("relock err_count", err_count, 1);
    span(VS0, 1, HT, HS); lines(VS0 + 1, VT);

    // Hsync width tolerance.
    lines(0, 1);
    span(1, 0, HT, HS - 1);
    check("hsync_len narrow", hsync_len, HS - 1);
    span(2, 0, HT, HS + 1);
    check("hsync_len wide", hsync_len, HS + 1);
    check("tolerated widths locked", locked, 1);
    check("tolerated widths err_count", err_count, 1);
    span(3, 0, HS0 + HS - 2, HS - 2);
    span(3, HS0 + HS - 2, HS0 + HS - 1, HS - 2);
    check("narrow err_hsync", a_err_hsync, 1);
    check("narrow hsync_len", hsync_len, HS - 2);
    check("narrow locked next cycle", b_locked, 0);
    check("narrow err_count next cycle", b_err_count, 2);
    span(3, HS0 + HS - 1, HT, HS - 2); lines(4, VT);

    // Short frame while in TRACK clears the good-frame run.
    lines(0, VT);
    lines(0, VT - 1);
    lines(0, VS0);
    span(VS0, 0, 1, HS);
    check("short frame err_frame", a_err_frame, 1);
    check("short frame frame_lines", frame_lines, VT - 1);
    check("short frame err_count", b_err_count, 3);
    span(VS0, 1, HT, HS); lines(VS0 + 1, VT);
    lines(0, VS0);
    span(VS0, 0, 1, HS);
    check("one clean frame not locked", a_locked, 0);
    span(VS0, 1, HT, HS); lines(VS0 + 1, VT);
    lines(0, VS0);
    span(VS0, 0, 1, HS);
    check("two clean frames locked", a_locked, 1);
    check("frame_lines after recovery", frame_lines, VT);

    // Long pixel_en=0 hold with toggling syncs.
    span(VS0, 1, HT, HS);
    span(VS0 + 1, 0, 10, HS);
    for (int i = 0; i < 1000; i++) begin
      hsync_n = i[0];
      vsync_n = i[1];
      @(posedge CLK_40); #1;
    end
    check("hold rx_x", rx_x, 9);
    check("hold rx_y", rx_y, VS0 + 1);
    check("hold rx_active", rx_active, 0);
    check("hold locked", locked, 1);
    check("hold line_len", line_len, HT);
    check("hold hsync_len", hsync_len, HS);
    check("hold err_count", err_count, 3);
    span(VS0 + 1, 10, HT, HS); lines(VS0 + 2, VT);
    lines(0, 3);
    span(3, 0, 5, HS);
    check("resume locked", locked, 1);
    check("resume err_count", err_count, 3);

    // Reset mid-frame while locked, with pixel_en high.
    reset = 1'b1; pixel_en = 1'b1; hsync_n = ~SP; vsync_n = ~SP;
    @(posedge CLK_40); #1;
    reset = 1'b0; pixel_en = 1'b0;
    check("mid reset rx_x", rx_x, 0);
    check("mid reset rx_y", rx_y, 0);
    check("mid reset locked", locked, 0);
    check("mid reset line_len", line_len, 0);
    check("mid reset hsync_len", hsync_len, 0);
    check("mid reset frame_lines", frame_lines, 0);
    check("mid reset err_count", err_count, 0);
    span(3, 5, HT, HS); lines(4, VT);
    lines(0, VT); lines(0, VT);
    lines(0, VS0);
    check("post reset locked before v4", locked, 0);
    span(VS0, 0, 1, HS);
    check("post reset locked at v4", a_locked, 1);
    span(VS0, 1, 4, HS);

    check("err_line pulse cycles", n_el, 1);
    check("err_hsync pulse cycles", n_eh, 1);
    check("err_frame pulse cycles", n_ef, 1);
    check("final err_count", err_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

Receive-side checker for the VGA sync stream produced by the design's horizontal/vertical sync generators. It samples hsync/vsync on each pixel clock enable, measures line length, hsync width and lines per frame, and reconstructs the pixel position (rx_x, rx_y) from the sync edges. It declares lock after consecutive clean frames and flags timing errors. It sits beside the VGA output pins as an on-chip debug and verification monitor, and drives no display logic.

## Interface
- H_AREA, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, expected hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_AREA, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 1, level of hsync_n/vsync_n during the sync pulse
- LOCK_FRAMES, 2, consecutive error-free frames required to lock (1..7)
- Derived: H_TOTAL = H_AREA+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_AREA+V_FP+V_SYNC+V_BP (525)

Ports:
- CLK_40  in  1  system clock
- reset  in  1  synchronous, active-high
- pixel_en  in  1  pixel clock enable; all sampling occurs only on cycles where it is 1
- hsync_n  in  1  horizontal sync from the generator
- vsync_n  in  1  vertical sync from the generator
- rx_x  out  11  reconstructed column, 0..H_TOTAL-1
- rx_y  out  10  reconstructed row, 0..V_TOTAL-1
- rx_active  out  1  locked && rx_x<H_AREA && rx_y<V_AREA
- locked  out  1  FSM in LOCKED
- line_len  out  11  last measured period between hsync leading edges (samples)
- hsync_len  out  11  last measured hsync width (samples)
- frame_lines  out  10  last measured count of hsync leading edges between vsync leading edges
- err_line  out  1  one-cycle pulse: line_len mismatch
- err_hsync  out  1  one-cycle pulse: hsync width error
- err_frame  out  1  one-cycle pulse: frame_lines mismatch
- err_count  out  8  saturating error total

## Operation
- "Sample" means a CLK_40 cycle with pixel_en=1. Registered previous-sample copies of hsync/vsync give the edges. Leading edge: level==SYNC_POL && prev!=SYNC_POL. Trailing edge: the opposite transition.
- h_cnt (11b, saturates at 2047): cleared to 0 on each hsync leading edge, otherwise +1 per sample. On the leading edge, line_len <= h_cnt+1 (saturating).
- hs_w (11b, saturating): counts samples with hsync at SYNC_POL. On the trailing edge, hsync_len <= hs_w and hs_w <= 0.
- v_cnt (10b, saturates at 1023): +1 per hsync leading edge. On a vsync leading edge, frame_lines <= v_cnt and v_cnt <= 0. When both leading edges fall on the same sample, the hsync edge is counted first.
- Checks, evaluated only in TRACK/LOCKED:
  - err_line: line_len != H_TOTAL, checked on each hsync leading edge except the first after entering TRACK.
  - err_hsync: |hsync_len − H_SYNC| > 1, checked on each trailing edge.
  - err_frame: frame_lines != V_TOTAL, checked on each vsync leading edge except the first after entering TRACK.
- err_count increments once per cycle in which any err_* pulses. It holds at 255.
- Position reconstruction:
  - An hsync leading edge loads rx_x <= H_AREA+H_FP (656).
  - Otherwise rx_x increments per sample, wrapping H_TOTAL-1 -> 0.
  - Each wrap increments rx_y, wrapping V_TOTAL-1 -> 0.
  - A vsync leading edge loads rx_y <= V_AREA+V_FP (490). This takes priority over a wrap on the same sample.
- FSM:
  - SEARCH: counters run, checks off, locked=0. The first vsync leading edge goes to TRACK and clears good_frames.
  - TRACK: on each vsync leading edge, an error-free preceding frame increments good_frames; any error in the frame clears it. When good_frames reaches LOCK_FRAMES, go to LOCKED.
  - LOCKED: any err_* pulse returns the FSM to SEARCH.
  - The first vsync edge in TRACK only starts the frame window and is not scored.

## Timing
- Reset: all outputs 0, all counters 0, prev sync registers = ~SYNC_POL, FSM = SEARCH.
- All outputs are registered.
- Measurements, rx_x/rx_y and err_* update on the CLK_40 edge that ends the sample cycle. Latency is 1 CLK_40 from the sample.
- err_* are high for exactly one CLK_40 cycle.
- locked rises on the cycle after the qualifying vsync sample.
- locked falls on the cycle after the error pulse; that error is included in err_count.
- Cycles with pixel_en=0 change no state.
- Reset asserted mid-frame returns to the reset state on the next edge, regardless of pixel_en.

## Test plan
- Nominal 640x480 stream, pixel_en 1-in-4 → locked=1 after the vsync leading edge that ends the 3rd full frame; line_len=800, hsync_len=96, frame_lines=525, err_count=0; rx_x=0/rx_y=0 on the first active pixel.
- One line shortened to 799 pixels while locked → err_line pulses once, locked drops the next cycle, err_count=1, relock after LOCK_FRAMES clean frames.
- hsync widths 95 and 97 → no error; width 94 → err_hsync.
- Frame of 524 lines while in TRACK → err_frame, good_frames cleared, no lock until two subsequent clean frames.
- Held pixel_en=0 for 1000 cycles mid-line → all outputs frozen; resume → no errors.
- Reset pulsed mid-frame while locked → all outputs 0 the next cycle; SEARCH; relock timing same as the nominal test.
